// File: rtl/wb_master_if.sv
// ----------------------------------------------------------------------------
// wb_master_if
//   Wishbone-style bus initiator between a CPU pipeline memory port and the
//   system bus master port. A single-cycle CPU request is registered onto the
//   bus and held until the slave acknowledges. The pipeline is stalled while
//   the access is outstanding. Read data is buffered if the pipeline is still
//   held by another stall source. Accesses never acknowledged within TIMEOUT
//   BUSY cycles are aborted with a one-cycle err_o pulse.
//
// Ports
//   clk                clock, rising edge
//   rst                asynchronous reset, active-low
//   cpu_ce_i           CPU access request
//   cpu_addr_i         byte address
//   cpu_data_i         write data
//   cpu_we_i           1 = write, 0 = read
//   cpu_sel_i          byte lanes (all-zero means all four lanes)
//   stall_i            pipeline held by another stall source
//   flush_i            pipeline flush, cancels any access
//   cpu_data_o         read data to CPU (combinational)
//   stallreq_o         stall request to pipeline control (combinational)
//   err_o              one-cycle pulse after a timeout abort (registered)
//   wishbone_addr_o    bus address (registered)
//   wishbone_data_o    bus write data (registered)
//   wishbone_we_o      bus write enable (registered)
//   wishbone_select_o  byte select, nonzero while a transaction is active
//   wishbone_data_i    bus read data
//   wishbone_ack_i     slave acknowledge
// ----------------------------------------------------------------------------
module wb_master_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        err_o,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_select_o,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i
);

    // Counter only has to reach TIMEOUT-1.
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_FOR_STALL
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   rbuf_q, rbuf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // ------------------------------------------------------------------
    // State / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rbuf_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rbuf_q  <= rbuf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rbuf_d  = rbuf_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    addr_d  = cpu_addr_i;
                    data_d  = cpu_data_i;
                    we_d    = cpu_we_i;
                    sel_d   = (cpu_sel_i == 4'b0000) ? 4'b1111 : cpu_sel_i;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else if (wishbone_ack_i) begin
                    // Writes return no data, so the buffer is zeroed to match cpu_data_o.
                    rbuf_d  = we_q ? '0 : wishbone_data_i;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = stall_i ? WAIT_FOR_STALL : IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    sel_d   = '0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_FOR_STALL: begin
                if (!stall_i || flush_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Combinational outputs to the pipeline
    // ------------------------------------------------------------------
    always_comb begin
        cpu_data_o = '0;
        stallreq_o = 1'b0;

        case (state_q)
            IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
            end
            BUSY: begin
                if (flush_i) begin
                    stallreq_o = 1'b0;
                end else if (wishbone_ack_i) begin
                    cpu_data_o = we_q ? '0 : wishbone_data_i;
                end else begin
                    // Release the pipeline on the abort cycle.
                    stallreq_o = (cnt_q != CNT_LAST);
                end
            end
            WAIT_FOR_STALL: begin
                cpu_data_o = rbuf_q;
            end
            default: ;
        endcase
    end

    assign wishbone_addr_o   = addr_q;
    assign wishbone_data_o   = data_q;
    assign wishbone_we_o     = we_q;
    assign wishbone_select_o = sel_q;
    assign err_o             = err_q;

endmodule
